// File: rtl/spm_seq_mult_if.sv
// Operand/handshake and serial/parallel product bundle for the serial-parallel multiplier.
// The master drives start and the operands; the slave returns the status and product signals.
interface spm_seq_mult_if #(
   parameter int WIDTH = 8
) ();
   logic               start;
   logic [WIDTH-1:0]   mc;
   logic [WIDTH-1:0]   mp;
   logic               busy;
   logic               p_bit;
   logic               p_valid;
   logic               done;
   logic [2*WIDTH-1:0] prod;

   modport master (
      output start, mc, mp,
      input  busy, p_bit, p_valid, done, prod
   );

   modport slave (
      input  start, mc, mp,
      output busy, p_bit, p_valid, done, prod
   );
endinterface

// File: rtl/spm_seq_mult.sv
// Serial-parallel carry-save multiplier: product bits stream out LSB first, one per cycle, for 2*WIDTH cycles.
// Start-to-done is 2*WIDTH cycles; start is ignored while busy, and is accepted again in the done cycle.
module spm_seq_mult #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   spm_seq_mult_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW);
   localparam logic [CW-1:0] LAST = CW'(PW - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mc_q, mp_q, sum_q, car_q;
   logic [PW-1:0]    sr_q, prod_q;
   logic [CW-1:0]    cnt_q;
   logic             p_bit_q, p_valid_q, done_q;

   logic             accept, ybit, last;
   logic [WIDTH-1:0] mc_src, sum_src, car_src, sum_d, car_d;
   logic [WIDTH:0]   sum_ext;
   logic [1:0]       t;
   logic [CW-1:0]    idx;
   logic [PW-1:0]    sr_d;

   // The accepting edge already performs step 0 on the fresh operands and a
   // cleared chain, so back-to-back multiplies stream without a bubble.
   always_comb begin
      accept  = (state_q == IDLE) && bus.start;
      last    = (state_q == RUN) && (cnt_q == LAST);
      mc_src  = accept ? bus.mc : mc_q;
      ybit    = accept ? bus.mp[0] : mp_q[0];
      sum_src = accept ? '0 : sum_q;
      car_src = accept ? '0 : car_q;
      sum_ext = {1'b0, sum_src};
      sum_d   = '0;
      car_d   = '0;
      t       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         t        = {1'b0, mc_src[i] & ybit} + {1'b0, car_src[i]} + {1'b0, sum_ext[i+1]};
         sum_d[i] = t[0];
         car_d[i] = t[1];
      end
      idx       = accept ? '0 : cnt_q;
      sr_d      = accept ? '0 : sr_q;
      sr_d[idx] = sum_d[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mc_q      <= '0;
         mp_q      <= '0;
         sum_q     <= '0;
         car_q     <= '0;
         sr_q      <= '0;
         prod_q    <= '0;
         cnt_q     <= '0;
         p_bit_q   <= 1'b0;
         p_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  mc_q      <= bus.mc;
                  mp_q      <= bus.mp >> 1;
                  sum_q     <= sum_d;
                  car_q     <= car_d;
                  sr_q      <= sr_d;
                  cnt_q     <= CW'(1);
                  p_bit_q   <= sum_d[0];
                  p_valid_q <= 1'b1;
                  state_q   <= RUN;
               end else begin
                  p_bit_q   <= 1'b0;
                  p_valid_q <= 1'b0;
               end
            end
            RUN: begin
               mp_q      <= mp_q >> 1;
               sum_q     <= sum_d;
               car_q     <= car_d;
               sr_q      <= sr_d;
               p_bit_q   <= sum_d[0];
               p_valid_q <= 1'b1;
               if (last) begin
                  prod_q  <= sr_d;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy    = (state_q == RUN);
   assign bus.p_bit   = p_bit_q;
   assign bus.p_valid = p_valid_q;
   assign bus.done    = done_q;
   assign bus.prod    = prod_q;
endmodule
